// File: rtl/sprite_fetch_arbiter_if.sv
// Request/response bundle between two sprite requesters, the fetch arbiter and the shared sprite ROM.
// Coordinates, ROM address and colour widths are fixed by the 96x64 RGB565 OLED sprite store.
interface sprite_fetch_arbiter_if;
   // Requester side
   logic        req_a;
   logic        req_b;
   logic [6:0]  x_a;
   logic [6:0]  x_b;
   logic [5:0]  y_a;
   logic [5:0]  y_b;
   logic        ack_a;
   logic        ack_b;

   // Shared combinational sprite ROM
   logic [12:0] rom_pixel_index;
   logic [15:0] rom_oled_colour;

   // Response path
   logic        rsp_valid_a;
   logic        rsp_valid_b;
   logic [15:0] rsp_colour;
   logic        rsp_transparent;

   modport master (
      output req_a, req_b, x_a, x_b, y_a, y_b, rom_oled_colour,
      input  ack_a, ack_b, rom_pixel_index,
             rsp_valid_a, rsp_valid_b, rsp_colour, rsp_transparent
   );

   modport slave (
      input  req_a, req_b, x_a, x_b, y_a, y_b, rom_oled_colour,
      output ack_a, ack_b, rom_pixel_index,
             rsp_valid_a, rsp_valid_b, rsp_colour, rsp_transparent
   );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Two-requester round-robin arbiter in front of a shared sprite ROM.
// Grants combinationally, registers the ROM address, then registers the colour: response two cycles after ack.
module sprite_fetch_arbiter #(
   parameter int unsigned SCR_W = 96,
   parameter int unsigned SCR_H = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_sync,
   sprite_fetch_arbiter_if.slave bus
);

   localparam int unsigned X_W    = 7;
   localparam int unsigned Y_W    = 6;
   localparam int unsigned IDX_W  = 13;
   localparam int unsigned COL_W  = 16;
   localparam int unsigned PROD_W = 24;

   localparam logic [0:0] PTR_A = 1'b0;
   localparam logic [0:0] PTR_B = 1'b1;

   // Priority pointer state
   logic [0:0]       r_ptr;
   logic [0:0]       w_ptr_next;
   logic [0:0]       w_ptr_eff;

   // Arbitration results
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_grant;

   // Granted request coordinates
   logic [X_W-1:0]   w_x;
   logic [Y_W-1:0]   w_y;
   logic [PROD_W-1:0] w_idx_full;
   logic [IDX_W-1:0] w_idx;
   logic             w_oor;

   // Stage 1: ROM address phase
   logic [IDX_W-1:0] r_rom_pixel_index;
   logic             r_s1_valid;
   logic             r_s1_owner_b;
   logic             r_s1_oor;

   // Stage 2: response phase
   logic [COL_W-1:0] w_colour;
   logic             r_rsp_valid_a;
   logic             r_rsp_valid_b;
   logic [COL_W-1:0] r_rsp_colour;
   logic             r_rsp_transparent;

   // Pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= PTR_A;
      end else begin
         r_ptr <= w_ptr_next;
      end
   end

   // Grant selection and pointer next-state; frame_sync forces A priority for this cycle only
   always_comb begin
      w_grant_a  = 1'b0;
      w_grant_b  = 1'b0;
      w_ptr_next = r_ptr;
      w_ptr_eff  = frame_sync ? PTR_A : r_ptr;

      if (!reset) begin
         if (bus.req_a && bus.req_b) begin
            if (w_ptr_eff == PTR_A) begin
               w_grant_a = 1'b1;
            end else begin
               w_grant_b = 1'b1;
            end
         end else if (bus.req_a) begin
            w_grant_a = 1'b1;
         end else if (bus.req_b) begin
            w_grant_b = 1'b1;
         end

         if (w_grant_a) begin
            w_ptr_next = PTR_B;
         end else if (w_grant_b) begin
            w_ptr_next = PTR_A;
         end
      end
   end

   assign w_grant = w_grant_a | w_grant_b;

   // Linear pixel index of the granted request
   always_comb begin
      w_x        = w_grant_b ? bus.x_b : bus.x_a;
      w_y        = w_grant_b ? bus.y_b : bus.y_a;
      w_idx_full = (PROD_W'(w_y) * PROD_W'(SCR_W)) + PROD_W'(w_x);
      w_idx      = IDX_W'(w_idx_full);
      w_oor      = (32'(w_x) >= SCR_W) || (32'(w_y) >= SCR_H);
   end

   // Stage 1: address holds when idle so the ROM input stays quiet
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rom_pixel_index <= '0;
         r_s1_valid        <= 1'b0;
         r_s1_owner_b      <= 1'b0;
         r_s1_oor          <= 1'b0;
      end else begin
         r_s1_valid   <= w_grant;
         r_s1_owner_b <= w_grant_b;
         r_s1_oor     <= w_grant & w_oor;
         if (w_grant) begin
            r_rom_pixel_index <= w_oor ? '0 : w_idx;
         end
      end
   end

   assign w_colour = r_s1_oor ? '0 : bus.rom_oled_colour;

   // Stage 2: colour and transparency hold between responses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid_a     <= 1'b0;
         r_rsp_valid_b     <= 1'b0;
         r_rsp_colour      <= '0;
         r_rsp_transparent <= 1'b0;
      end else begin
         r_rsp_valid_a <= r_s1_valid & ~r_s1_owner_b;
         r_rsp_valid_b <= r_s1_valid &  r_s1_owner_b;
         if (r_s1_valid) begin
            r_rsp_colour      <= w_colour;
            r_rsp_transparent <= (w_colour == '0);
         end
      end
   end

   assign bus.ack_a           = w_grant_a;
   assign bus.ack_b           = w_grant_b;
   assign bus.rom_pixel_index = r_rom_pixel_index;
   assign bus.rsp_valid_a     = r_rsp_valid_a;
   assign bus.rsp_valid_b     = r_rsp_valid_b;
   assign bus.rsp_colour      = r_rsp_colour;
   assign bus.rsp_transparent = r_rsp_transparent;

endmodule
